// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the execute-stage ALU.
//   alu_op_e  - 3-bit operation select encoding
//   ALU_WIDTH - default operand/result width
// Optional feature macro used by the ALU files: ALU_ARITH_FLAGS_EN
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_e;

endpackage

// File: rtl/alu_comb.sv
// alu_comb: purely combinational ALU datapath.
// Ports:
//   op_i       - operation select (alu_op_e)
//   a_i, b_i   - operands (b_i low SHAMT_W bits double as shift amount)
//   result_o   - operation result
//   carry_o    - ADD carry-out / SUB borrow (only with ALU_ARITH_FLAGS_EN)
//   overflow_o - signed overflow for ADD/SUB (only with ALU_ARITH_FLAGS_EN)
// Macro: ALU_ARITH_FLAGS_EN adds carry_o/overflow_o and their logic.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  alu_op_e          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o
`ifdef ALU_ARITH_FLAGS_EN
  ,
  output logic             carry_o,
  output logic             overflow_o
`endif
);

  localparam int SHAMT_W = $clog2(WIDTH);

  logic [WIDTH-1:0]   add_res;
  logic [WIDTH-1:0]   sub_res;
  logic [SHAMT_W-1:0] shamt;
  logic               slt;

`ifdef ALU_ARITH_FLAGS_EN
  logic add_c;
  logic sub_b;

  // One extra bit on top of the adder exposes carry-out; for the
  // subtractor the same bit is the unsigned borrow (a < b).
  assign {add_c, add_res} = {1'b0, a_i} + {1'b0, b_i};
  assign {sub_b, sub_res} = {1'b0, a_i} - {1'b0, b_i};

  logic add_ovf;
  logic sub_ovf;

  // Signed overflow: operands of like sign (ADD) or unlike sign (SUB)
  // producing a result whose sign differs from a_i.
  assign add_ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (add_res[WIDTH-1] != a_i[WIDTH-1]);
  assign sub_ovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (sub_res[WIDTH-1] != a_i[WIDTH-1]);

  always_comb begin
    carry_o    = 1'b0;
    overflow_o = 1'b0;
    case (op_i)
      ALU_ADD: begin
        carry_o    = add_c;
        overflow_o = add_ovf;
      end
      ALU_SUB: begin
        carry_o    = sub_b;
        overflow_o = sub_ovf;
      end
      default: begin
        carry_o    = 1'b0;
        overflow_o = 1'b0;
      end
    endcase
  end
`else
  assign add_res = a_i + b_i;
  assign sub_res = a_i - b_i;
`endif

  // Upper bits of b_i are ignored for shifts.
  assign shamt = b_i[SHAMT_W-1:0];
  assign slt   = $signed(a_i) < $signed(b_i);

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD: result_o = add_res;
      ALU_SUB: result_o = sub_res;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_XOR: result_o = a_i ^ b_i;
      ALU_SLL: result_o = a_i << shamt;
      ALU_SRL: result_o = a_i >> shamt;
      ALU_SLT: result_o = {{(WIDTH-1){1'b0}}, slt};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// alu: registered integer ALU for the execute stage, latency one clock.
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous active-high reset
//   in_valid  - operands/opcode valid this cycle
//   alu_op    - operation select (see alu_pkg::alu_op_e)
//   in1, in2  - operands (in2 low bits are the shift amount)
//   out       - registered result (held when in_valid=0)
//   out_valid - out/flags hold a result captured on the last edge
//   zero      - out == 0
//   negative  - out[WIDTH-1]
//   carry     - ADD carry / SUB borrow (only with ALU_ARITH_FLAGS_EN)
//   overflow  - ADD/SUB signed overflow (only with ALU_ARITH_FLAGS_EN)
// Macro: ALU_ARITH_FLAGS_EN adds the carry/overflow ports and registers.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             zero,
  output logic             negative
`ifdef ALU_ARITH_FLAGS_EN
  ,
  output logic             carry,
  output logic             overflow
`endif
);

  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] out_d,   out_q;
  logic             valid_d, valid_q;

`ifdef ALU_ARITH_FLAGS_EN
  logic res_carry;
  logic res_ovf;
  logic carry_d, carry_q;
  logic ovf_d,   ovf_q;
`endif

  alu_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .op_i       (alu_op_e'(alu_op)),
    .a_i        (in1),
    .b_i        (in2),
    .result_o   (res)
`ifdef ALU_ARITH_FLAGS_EN
    ,
    .carry_o    (res_carry),
    .overflow_o (res_ovf)
`endif
  );

  always_comb begin
    out_d   = out_q;
    valid_d = in_valid;
    if (in_valid) begin
      out_d = res;
    end
  end

`ifdef ALU_ARITH_FLAGS_EN
  always_comb begin
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (in_valid) begin
      carry_d = res_carry;
      ovf_d   = res_ovf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign carry    = carry_q;
  assign overflow = ovf_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  // Flags decode the registered result, so reset (out=0) yields zero=1.
  assign out       = out_q;
  assign out_valid = valid_q;
  assign zero      = (out_q == '0);
  assign negative  = out_q[WIDTH-1];

endmodule

// File: tb/tb_alu.sv
module tb_alu;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [2:0]   alu_op;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic [W-1:0] out;
  logic         out_valid;
  logic         zero;
  logic         negative;
`ifdef ALU_ARITH_FLAGS_EN
  logic         carry;
  logic         overflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .alu_op    (alu_op),
    .in1       (in1),
    .in2       (in2),
    .out       (out),
    .out_valid (out_valid),
    .zero      (zero),
    .negative  (negative)
`ifdef ALU_ARITH_FLAGS_EN
    ,
    .carry     (carry),
    .overflow  (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_out;
    logic         exp_zero;
    logic         exp_neg;
  } vec_t;

  vec_t vecs[$];

  // Reference model written from the opcode definitions.
  function automatic logic [W-1:0] ref_result(input logic [2:0] op,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    longint unsigned ua, ub, sh;
    ua = longint'(a);
    ub = longint'(b);
    sh = ub % W;
    case (op)
      3'd0: return W'((ua + ub) % (64'd1 << W));
      3'd1: return W'((ua + (64'd1 << W) - ub) % (64'd1 << W));
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return W'((ua * (64'd1 << sh)) % (64'd1 << W));
      3'd6: return W'(ua / (64'd1 << sh));
      default: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
    endcase
  endfunction

`ifdef ALU_ARITH_FLAGS_EN
  function automatic logic ref_carry(input logic [2:0] op,
                                     input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    if (op == 3'd0) return (longint'(a) + longint'(b)) >= (64'sd1 <<< W);
    if (op == 3'd1) return a < b;
    return 1'b0;
  endfunction

  function automatic logic ref_ovf(input logic [2:0] op,
                                   input logic [W-1:0] a,
                                   input logic [W-1:0] b);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 3'd0)      r = sa + sb;
    else if (op == 3'd1) r = sa - sb;
    else return 1'b0;
    return (r > ((64'sd1 <<< (W-1)) - 1)) || (r < -(64'sd1 <<< (W-1)));
  endfunction
`endif

  task automatic check(input string name, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [W-1:0] e_out,
                           input logic e_valid);
    check({name, ".out"},       out,             e_out);
    check({name, ".out_valid"}, W'(out_valid),   W'(e_valid));
    check({name, ".zero"},      W'(zero),        W'(e_out == '0));
    check({name, ".negative"},  W'(negative),    W'(e_out[W-1]));
  endtask

  // Drive inputs just after an edge, let the next edge capture them,
  // and return 1 time unit after that edge.
  task automatic apply(input logic v, input logic [2:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = v;
    alu_op   = op;
    in1      = a;
    in2      = b;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [W-1:0] e);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp_out = e;
    v.exp_zero = (e == '0);
    v.exp_neg  = e[W-1];
    return v;
  endfunction

  logic [W-1:0] m_out;
  logic [2:0]   r_op;
  logic [W-1:0] r_a, r_b;
  logic         r_v;

  initial begin
    rst = 1'b1; in_valid = 1'b0; alu_op = 3'd0; in1 = '0; in2 = '0;

    vecs.push_back(mk(3'd0, 32'd2, 32'd1, 32'd3));
    vecs.push_back(mk(3'd1, 32'd2, 32'd1, 32'd1));
    vecs.push_back(mk(3'd2, 32'd2, 32'd1, 32'd0));
    vecs.push_back(mk(3'd3, 32'd2, 32'd1, 32'd3));
    vecs.push_back(mk(3'd4, 32'd2, 32'd1, 32'd3));
    vecs.push_back(mk(3'd5, 32'd2, 32'd1, 32'd4));
    vecs.push_back(mk(3'd6, 32'd2, 32'd1, 32'd1));
    vecs.push_back(mk(3'd7, 32'd2, 32'd1, 32'd0));
    vecs.push_back(mk(3'd1, 32'd0, 32'd1, 32'hFFFF_FFFF));
    vecs.push_back(mk(3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0));
    vecs.push_back(mk(3'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000));
    vecs.push_back(mk(3'd7, 32'hFFFF_FFFF, 32'd1, 32'd1));
    vecs.push_back(mk(3'd7, 32'd1, 32'hFFFF_FFFF, 32'd0));
    vecs.push_back(mk(3'd5, 32'd1, 32'd33, 32'd2));
    vecs.push_back(mk(3'd6, 32'h8000_0000, 32'd31, 32'd1));

    // Reset state held while rst is high.
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", '0, 1'b0);
    #2 rst = 1'b0;

    // Directed table.
    for (int i = 0; i < vecs.size(); i++) begin
      apply(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d.out", i), out, vecs[i].exp_out);
      check($sformatf("vec%0d.valid", i), W'(out_valid), W'(1));
      check($sformatf("vec%0d.zero", i), W'(zero), W'(vecs[i].exp_zero));
      check($sformatf("vec%0d.neg", i), W'(negative), W'(vecs[i].exp_neg));
`ifdef ALU_ARITH_FLAGS_EN
      check($sformatf("vec%0d.carry", i), W'(carry),
            W'(ref_carry(vecs[i].op, vecs[i].a, vecs[i].b)));
      check($sformatf("vec%0d.ovf", i), W'(overflow),
            W'(ref_ovf(vecs[i].op, vecs[i].a, vecs[i].b)));
`endif
    end

    // Hold: ADD 2+1 then three idle cycles with changing inputs.
    apply(1'b1, 3'd0, 32'd2, 32'd1);
    check_all("hold.cap", 32'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 3'(i + 1), 32'(i * 7 + 5), 32'(i + 9));
      check_all($sformatf("hold%0d", i), 32'd3, 1'b0);
    end

    // Back-to-back stream, one result per cycle in order.
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 3'd0, 32'(i * 100), 32'(i));
      check_all($sformatf("b2b%0d", i), 32'(i * 101), 1'b1);
    end

    // Asynchronous reset asserted mid-cycle, no clock edge needed.
    apply(1'b1, 3'd1, 32'd0, 32'd5);
    check_all("prerst", 32'hFFFF_FFFB, 1'b1);
    #3 rst = 1'b1;
    #1;
    check_all("async_rst", '0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    // First edge after release captures normally.
    in_valid = 1'b1; alu_op = 3'd0; in1 = 32'd2; in2 = 32'd1;
    @(posedge clk);
    #1;
    check_all("first_cap", 32'd3, 1'b1);

    // Randomized stream against the reference model.
    m_out = 32'd3;
    for (int i = 0; i < 400; i++) begin
      r_v  = ($urandom_range(0, 3) != 0);
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 70)) : $urandom;
      if ($urandom_range(0, 9) == 0) r_a = 32'h8000_0000;
      apply(r_v, r_op, r_a, r_b);
      if (r_v) m_out = ref_result(r_op, r_a, r_b);
      check_all($sformatf("rnd%0d", i), m_out, r_v);
`ifdef ALU_ARITH_FLAGS_EN
      if (r_v) begin
        check($sformatf("rnd%0d.carry", i), W'(carry), W'(ref_carry(r_op, r_a, r_b)));
        check($sformatf("rnd%0d.ovf", i), W'(overflow), W'(ref_ovf(r_op, r_a, r_b)));
      end
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
